// File: rtl/hazard_ctrl_if.sv
// Decode-side and control-side signals of the pipeline hazard unit.
// The slave modport belongs to hazard_ctrl; the master modport belongs to the pipeline driving it.
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic                  id_wr_en;
    logic [REG_ADDR_W-1:0] id_wr_reg;
    logic                  id_is_load;
    logic                  ex_redirect;

    logic                  stall_f;
    logic                  bubble_e;
    logic                  flush_d;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_wr_en, id_wr_reg, id_is_load, ex_redirect,
        input  stall_f, bubble_e, flush_d, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_wr_en, id_wr_reg, id_is_load, ex_redirect,
        output stall_f, bubble_e, flush_d, fwd_a_sel, fwd_b_sel,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard unit: tracks the instructions in EX, MEM and WB, stalls or
// flushes decode, selects EX operand forwarding, and counts stall and flush cycles.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 3,
    parameter int FWD_EN     = 1,
    parameter int WB_BYPASS  = 1,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] wr_reg;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  rs1_used;
        logic                  rs2_used;
    } slot_t;

    slot_t            id_slot;
    slot_t            slot_e;
    slot_t            slot_m;
    slot_t            slot_wb;
    logic             hit_e;
    logic             hit_m;
    logic             hit_wb;
    logic             hz;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    function automatic logic id_hits(input slot_t s, input slot_t id);
        return s.valid && s.wr_en && id.valid &&
               ((id.rs1_used && (id.rs1 == s.wr_reg)) ||
                (id.rs2_used && (id.rs2 == s.wr_reg)));
    endfunction

    // A load still in MEM has no data yet, so it never feeds EX; the youngest ALU result wins.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_ADDR_W-1:0] rs,
                                           input slot_t m, input slot_t wb);
        if (used && m.valid && m.wr_en && !m.is_load && (m.wr_reg == rs))
            return 2'b01;
        if (used && wb.valid && wb.wr_en && (wb.wr_reg == rs))
            return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        id_slot.valid    = bus.id_valid;
        id_slot.wr_en    = bus.id_wr_en;
        id_slot.wr_reg   = bus.id_wr_reg;
        id_slot.is_load  = bus.id_is_load;
        id_slot.rs1      = bus.id_rs1;
        id_slot.rs2      = bus.id_rs2;
        id_slot.rs1_used = bus.id_rs1_used;
        id_slot.rs2_used = bus.id_rs2_used;
    end

    always_comb begin
        hit_e  = id_hits(slot_e, id_slot);
        hit_m  = id_hits(slot_m, id_slot);
        hit_wb = id_hits(slot_wb, id_slot);
        if (FWD_EN != 0)
            hz = hit_e && slot_e.is_load;
        else
            hz = hit_e || hit_m || ((WB_BYPASS == 0) && hit_wb);
    end

    // A taken redirect squashes decode outright, so any pending stall is moot that cycle.
    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        fwd_a  = 2'b00;
        fwd_b  = 2'b00;
        if (!rst) begin
            if (bus.ex_redirect) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else begin
                stall  = hz;
                bubble = hz;
            end
            if ((FWD_EN != 0) && slot_e.valid) begin
                fwd_a = fwd_sel(slot_e.rs1_used, slot_e.rs1, slot_m, slot_wb);
                fwd_b = fwd_sel(slot_e.rs2_used, slot_e.rs2, slot_m, slot_wb);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_e.valid  <= 1'b0;
            slot_m.valid  <= 1'b0;
            slot_wb.valid <= 1'b0;
            stall_count   <= '0;
            flush_count   <= '0;
        end else begin
            slot_wb      <= slot_m;
            slot_m       <= slot_e;
            slot_e       <= id_slot;
            slot_e.valid <= bus.id_valid && !bubble && !flush;
            if (stall && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (flush && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    assign bus.stall_f   = stall;
    assign bus.bubble_e  = bubble;
    assign bus.flush_d   = flush;
    assign bus.fwd_a_sel = fwd_a;
    assign bus.fwd_b_sel = fwd_b;
    assign bus.stall_cnt = stall_count;
    assign bus.flush_cnt = flush_count;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 3, register-specifier width (2**REG_ADDR_W architectural registers).
REQ-002 SHALL have parameter FWD_EN, default 1: 1 = forwarding mode, only load-use stalls; 0 = stall-only mode.
REQ-003 SHALL have parameter WB_BYPASS, default 1: 1 = register file writes-before-reads, so the WB slot never causes a stall.
REQ-004 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-005 SHALL use one clock with a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-006 SHALL have these decode-stage inputs:
- id_valid  input  1  IF/ID holds a real instruction.
- id_rs1, id_rs2  input  REG_ADDR_W  source specifiers.
- id_rs1_used, id_rs2_used  input  1  source actually read.
- id_wr_en  input  1  instruction writes a register.
- id_wr_reg  input  REG_ADDR_W  destination specifier.
- id_is_load  input  1  instruction is a memory load.
REQ-007 SHALL have ex_redirect  input  1: EX-slot instruction is a taken branch/jump this cycle.
REQ-008 SHALL have these control outputs:
- stall_f  output  1  hold PC and IF/ID.
- bubble_e  output  1  write NOP into ID/EX.
- flush_d  output  1  squash IF/ID.
REQ-009 SHALL have fwd_a_sel, fwd_b_sel  output  2 each: EX operand source select; 00 = regfile, 01 = EX/MEM, 10 = MEM/WB.
REQ-010 SHALL have stall_cnt, flush_cnt  output  CNT_W each: saturating event counters.

Function
REQ-011 SHALL keep internal tracking slots E, M and WB. Each slot holds: valid, wr_en, wr_reg, is_load, rs1, rs2, rs1_used, rs2_used.
REQ-012 SHALL advance slots every cycle: WB<=M, M<=E unconditionally; E<=ID fields with valid=id_valid & ~bubble_e & ~flush_d.
REQ-013 SHALL treat a slot as a hazard source only when valid & wr_en; register 0 is an ordinary register.
REQ-014 SHALL compute the raw match for a source as (rsN_used & id_valid & rsN == slot.wr_reg) against each hazard-source slot.
REQ-015 SHALL, when FWD_EN=0, raise hz when either source matches E or M, or matches WB while WB_BYPASS=0.
REQ-016 SHALL, when FWD_EN=1, raise hz only when either source matches E and E.is_load=1 (one-cycle load-use stall).
REQ-017 SHALL drive stall_f=bubble_e=hz, combinationally in the same cycle, when ex_redirect=0.
REQ-018 SHALL drive flush_d=1, bubble_e=1, stall_f=0 whenever ex_redirect=1; redirect overrides hz in the same cycle.
REQ-019 SHALL, when FWD_EN=1, set fwd_a_sel per E.rs1: 01 if E.rs1_used and M matches, else 10 if WB matches, else 00.
REQ-020 SHALL set fwd_b_sel identically from E.rs2. Priority is M over WB (youngest wins).
REQ-021 SHALL drive fwd_a_sel=fwd_b_sel=00 at all times when FWD_EN=0 or E.valid=0.
REQ-022 SHALL NOT select forwarding from an M slot with is_load=1; such an operand resolves via WB the next cycle.
REQ-023 SHALL increment stall_cnt by 1 in each cycle with stall_f=1 and flush_cnt in each cycle with flush_d=1; both saturate at all-ones with no wrap.
REQ-024 SHALL, during a multi-cycle stall, hold the ID instruction; E receives invalid entries, and the stall releases on the first cycle the condition clears.

Reset
REQ-025 SHALL, on any clock edge with rst=1, clear all slot valid bits and both counters.
REQ-026 SHALL force stall_f, bubble_e, flush_d=0 and fwd selects=00 while rst=1, regardless of other inputs.
REQ-027 SHALL raise no hazard on the first cycle after reset release, because all slots are invalid, including when id_rs matches a stale wr_reg value.
REQ-028 SHALL, when rst is asserted mid-stall, end the stall the next cycle; the pre-reset E/M/WB contents never cause hazards or forwarding.

Verification
REQ-029 SHALL cover load-use (FWD_EN=1): LD r3 then ADD r4,r3,r1 -> stall_f=1 for exactly 1 cycle, then fwd_a_sel=10 with ADD in EX; stall_cnt=1.
REQ-030 SHALL cover ALU back-to-back (FWD_EN=1): ADD r2, then SUB r5,r2,r2 -> no stall; fwd_a_sel=fwd_b_sel=01.
REQ-031 SHALL cover stall-only (FWD_EN=0, WB_BYPASS=1): ADD r2 then use of r2 -> stall_f=1 for 2 cycles, then released.
REQ-032 SHALL cover redirect during hazard: ex_redirect=1 with hz=1 -> flush_d=1, stall_f=0, bubble_e=1; flush_cnt +1; stall_cnt unchanged.
REQ-033 SHALL cover counter saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=15, holding at 15.
REQ-034 SHALL cover reset mid-stall: rst asserted for 1 cycle during a load-use stall -> all outputs 0 in the reset cycle and after; counters read 0.
